// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO.
// Bit timing comes from an internal sysclk divider.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             tx_en,
    input  logic [7:0]       tx_data,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_overflow,
    output logic [CNT_W-1:0] fifo_count,
    output logic             UART_TXD
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [15:0]      div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    logic             tick;
    logic             pop;
    logic             wr;

    assign tick = (div_q == DIV_MAX);
    // Fullness is judged on the registered count, so a pop never frees a slot early.
    assign wr   = tx_en && (count_q != FULL);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        ovf_d    = tx_en && !ready_q;
        pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = START;
                    div_d   = '0;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                div_d = tick ? '0 : div_q + 16'd1;
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                div_d = tick ? '0 : div_q + 16'd1;
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                div_d = tick ? '0 : div_q + 16'd1;
                if (tick) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        txd_d   = 1'b1;
                    end
                end
            end
        endcase

        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        unique case ({wr, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != FULL);
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
        end
    end

    assign UART_TXD    = txd_q;
    assign tx_busy     = busy_q;
    assign tx_overflow = ovf_q;
    assign tx_ready    = ready_q;
    assign fifo_count  = count_q;

endmodule
